laser_aom_dac_drv: RTL

LASER_AOM_DAC_DRV -- requirements
Module: laser_aom_dac_drv

---
 rtl/laser_aom_dac_drv_pkg.sv | 26 ++
 rtl/laser_aom_dac_drv_if.sv | 27 ++
 rtl/laser_aom_dac_drv_overload_mon.sv | 45 ++++
 rtl/laser_aom_dac_drv.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/laser_aom_dac_drv_pkg.sv
// rtl/laser_aom_dac_drv_pkg.sv - shared laser package: FSM states, DAC frame format, defaults
// Holds the state encoding, the 16-bit DAC frame layout {PD, code, pad} and
// the default SCLK half-period used by laser_aom_dac_drv.
package laser_aom_dac_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STOP  = 2'd3
    } dac_state_e;

    localparam int          CODE_W       = 12;
    localparam int          FRAME_W      = 16;
    localparam logic [1:0]  PD_BITS      = 2'b00;
    localparam logic [1:0]  PAD_BITS     = 2'b00;
    localparam int          HALF_CNT     = 2 * FRAME_W;
    localparam int          SCLK_DIV_DEF = 4;
    localparam int          CNT_W        = 9;
    localparam int          OVL_CNT_W    = 32;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [CODE_W-1:0] code);
        return {PD_BITS, code, PAD_BITS};
    endfunction

endpackage

// File: rtl/laser_aom_dac_drv_if.sv
// rtl/laser_aom_dac_drv_if.sv - link between the DAC driver and its overload monitor
// master (driver side): supplies current DAC code, threshold, timeout, clear and
//   the raw requested code; receives the clamped code, forced-zero strobe, flag.
// slave (monitor side): the mirror image.
interface laser_aom_dac_drv_if;
    import laser_aom_dac_drv_pkg::*;

    logic [CODE_W-1:0]    dac_code;
    logic [CODE_W-1:0]    thre;
    logic [OVL_CNT_W-1:0] timeout;
    logic                 clr;
    logic [CODE_W-1:0]    req_code;
    logic [CODE_W-1:0]    req_code_clamped;
    logic                 force_zero;
    logic                 flag;

    modport master (
        output dac_code, thre, timeout, clr, req_code,
        input  req_code_clamped, force_zero, flag
    );

    modport slave (
        input  dac_code, thre, timeout, clr, req_code,
        output req_code_clamped, force_zero, flag
    );

endinterface

// File: rtl/laser_aom_dac_drv_overload_mon.sv
// rtl/laser_aom_dac_drv_overload_mon.sv - overload time counter, sticky flag and code clamp
// Ports: clk_i, rst_i (sync, active high); mon = slave side of laser_aom_dac_drv_if.
module laser_aom_overload_mon
    import laser_aom_dac_drv_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    laser_aom_dac_drv_if.slave   mon
);

    logic [OVL_CNT_W-1:0] ovl_cnt;
    logic [OVL_CNT_W-1:0] cnt_inc;
    logic                 over;
    logic                 set_now;
    logic                 flag_q;

    always_comb begin
        over    = (mon.dac_code > mon.thre);
        cnt_inc = (&ovl_cnt) ? ovl_cnt : ovl_cnt + 1'b1;
        // Fire on the edge the counter steps onto the timeout, once; a counter
        // already parked there (saturated) must not retrigger the forced write.
        set_now = over && (mon.timeout != '0) && (cnt_inc == mon.timeout)
                  && (ovl_cnt != mon.timeout);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovl_cnt <= '0;
            flag_q  <= 1'b0;
        end else if (set_now) begin
            ovl_cnt <= cnt_inc;
            flag_q  <= 1'b1;
        end else if (mon.clr) begin
            ovl_cnt <= '0;
            flag_q  <= 1'b0;
        end else begin
            ovl_cnt <= over ? cnt_inc : '0;
        end
    end

    assign mon.force_zero       = set_now;
    assign mon.flag             = flag_q;
    assign mon.req_code_clamped = (flag_q && (mon.req_code > mon.thre)) ? mon.thre : mon.req_code;

endmodule

// File: rtl/laser_aom_dac_drv.sv
// rtl/laser_aom_dac_drv.sv - serial DAC driver for the AOM with coalescing and overload guard
// Ports: clk_i, rst_i (sync, active high); aom_en_i/aom_voltage_i update request;
//   overload_vol_thre_i/overload_timeout_i/overload_clr_i overload control;
//   DAC_SYNC_N/DAC_SCLK/DAC_SDIN serial pins; dac_busy_o, dac_code_o, overload_flag_o status.
module laser_aom_dac_drv
    import laser_aom_dac_drv_pkg::*;
#(
    parameter real TCQ      = 0.1,
    parameter int  SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 aom_en_i,
    input  logic [CODE_W-1:0]    aom_voltage_i,
    input  logic [CODE_W-1:0]    overload_vol_thre_i,
    input  logic [OVL_CNT_W-1:0] overload_timeout_i,
    input  logic                 overload_clr_i,
    output logic                 DAC_SYNC_N,
    output logic                 DAC_SCLK,
    output logic                 DAC_SDIN,
    output logic                 dac_busy_o,
    output logic [CODE_W-1:0]    dac_code_o,
    output logic                 overload_flag_o
);

    if (SCLK_DIV < 2 || SCLK_DIV > 255 || TCQ < 0.0) begin : g_param_check
        $error("laser_aom_dac_drv: SCLK_DIV must be 2..255 and TCQ non-negative");
    end

    localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] STOP_M1   = CNT_W'(2 * SCLK_DIV - 1);
    localparam logic [4:0]       LAST_HALF = 5'(HALF_CNT - 1);

    laser_aom_dac_drv_if mon_if ();

    assign mon_if.dac_code = dac_code_o;
    assign mon_if.thre     = overload_vol_thre_i;
    assign mon_if.timeout  = overload_timeout_i;
    assign mon_if.clr      = overload_clr_i;
    assign mon_if.req_code = aom_voltage_i;
    assign overload_flag_o = mon_if.flag;

    laser_aom_overload_mon u_overload_mon (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .mon   (mon_if.slave)
    );

    dac_state_e          state_q;
    logic [CODE_W-1:0]   pend_code;
    logic                pend_vld;
    logic                load;
    logic [FRAME_W-1:0]  next_frame;
    logic [FRAME_W-2:0]  shreg;
    logic [CODE_W-1:0]   frame_code;
    logic [CNT_W-1:0]    cnt;
    logic [4:0]          half;

    assign load       = (state_q == ST_IDLE) && pend_vld;
    assign next_frame = make_frame(pend_code);

    // Any write beats the load-clear, so a request landing on the load cycle
    // survives as the next pending frame. The overload zero beats requests.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_code <= '0;
            pend_vld  <= 1'b0;
        end else if (mon_if.force_zero) begin
            pend_code <= '0;
            pend_vld  <= 1'b1;
        end else if (aom_en_i) begin
            pend_code <= mon_if.req_code_clamped;
            pend_vld  <= 1'b1;
        end else if (load) begin
            pend_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            DAC_SYNC_N <= 1'b1;
            DAC_SCLK   <= 1'b1;
            DAC_SDIN   <= 1'b0;
            dac_busy_o <= 1'b0;
            dac_code_o <= '0;
            frame_code <= '0;
            shreg      <= '0;
            cnt        <= '0;
            half       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_vld) begin
                        shreg      <= next_frame[FRAME_W-2:0];
                        DAC_SDIN   <= next_frame[FRAME_W-1];
                        frame_code <= pend_code;
                        DAC_SYNC_N <= 1'b0;
                        dac_busy_o <= 1'b1;
                        cnt        <= '0;
                        state_q    <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == DIV_M1) begin
                        cnt      <= '0;
                        half     <= '0;
                        DAC_SCLK <= 1'b0;
                        state_q  <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == DIV_M1) begin
                        cnt <= '0;
                        if (half == LAST_HALF) begin
                            DAC_SYNC_N <= 1'b1;
                            DAC_SCLK   <= 1'b1;
                            DAC_SDIN   <= 1'b0;
                            dac_code_o <= frame_code;
                            state_q    <= ST_STOP;
                        end else begin
                            half     <= half + 5'd1;
                            DAC_SCLK <= ~DAC_SCLK;
                            // Leaving an even half means SCLK rises: present next bit.
                            if (!half[0]) begin
                                DAC_SDIN <= shreg[FRAME_W-2];
                                shreg    <= {shreg[FRAME_W-3:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt == STOP_M1) begin
                        cnt        <= '0;
                        dac_busy_o <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
